// File: rtl/dot_seq.sv
// dot_seq: operand sequencer and result collector in front of a mac stage.
// Feeds accepted operand pairs to the mac, clears it on the first pair of
// each k_len-long dot product, and captures finished sums into a 2-entry FIFO.
// Optional: define DOT_SEQ_LAST_CHECK_EN to add in_last and a sticky len_err.
module dot_seq #(
    parameter int NBITS = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_a,
    input  logic [NBITS-1:0]   in_b,
    output logic [NBITS-1:0]   mac_a,
    output logic [NBITS-1:0]   mac_b,
    output logic               mac_clear,
    input  logic [2*NBITS-1:0] mac_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*NBITS-1:0] out_data,
    output logic [CNT_W-1:0]   out_count
`ifdef DOT_SEQ_LAST_CHECK_EN
    ,
    input  logic               in_last,
    output logic               len_err
`endif
);

    typedef enum logic {ST_FIRST, ST_BODY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d, idx_q, idx_d, cnt_q, cnt_d;
    logic               cap_q, cap_d;
    logic [1:0]         fcnt_q, fcnt_d;
    logic [2*NBITS-1:0] d0_q, d0_d, d1_q, d1_d;
    logic               accept, first, is_last, push, pop;
    logic [CNT_W-1:0]   k_eff, idx_nxt;
    logic [1:0]         wpos;

    assign first     = (state_q == ST_FIRST);
    assign k_eff     = (k_len == '0) ? CNT_W'(1) : k_len;
    assign idx_nxt   = first ? CNT_W'(1) : idx_q + CNT_W'(1);
    assign is_last   = (idx_nxt == (first ? k_eff : len_q));
    // A pending capture reserves a FIFO slot, so a capture never finds it full.
    assign in_ready  = reset && ((fcnt_q + 2'(cap_q)) < 2'd2);
    assign accept    = in_valid && in_ready;
    // Idle cycles feed zeros so the mac simply holds its sum across gaps.
    assign mac_a     = accept ? in_a : '0;
    assign mac_b     = accept ? in_b : '0;
    assign mac_clear = (accept && first) || !reset;
    assign push      = cap_q;
    assign out_valid = (fcnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = d0_q;
    assign out_count = cnt_q;
    assign wpos      = fcnt_q - 2'(pop);

    // Next-state for product tracking and the result FIFO.
    always_comb begin
        state_d = accept ? (is_last ? ST_FIRST : ST_BODY) : state_q;
        idx_d   = accept ? idx_nxt : idx_q;
        len_d   = (accept && first) ? k_eff : len_q;
        cap_d   = accept && is_last;
        d0_d    = (push && wpos == 2'd0) ? mac_acc : (pop && fcnt_q == 2'd2) ? d1_q : d0_q;
        d1_d    = (push && wpos == 2'd1) ? mac_acc : d1_q;
        fcnt_d  = fcnt_q + 2'(push) - 2'(pop);
        cnt_d   = cnt_q + CNT_W'(push);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FIRST;
            len_q   <= '0;
            idx_q   <= '0;
            cap_q   <= 1'b0;
            fcnt_q  <= 2'd0;
            d0_q    <= '0;
            d1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            fcnt_q  <= fcnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DOT_SEQ_LAST_CHECK_EN
    logic err_q;
    assign len_err = err_q;
    // Sticky flag: in_last disagreed with the count-based last pair.
    always_ff @(posedge clk) begin
        if (!reset)
            err_q <= 1'b0;
        else
            err_q <= err_q | (accept && (in_last != is_last));
    end
`endif

endmodule

// File: tb/tb_dot_seq.sv
// tb_dot_seq: self-checking bench for dot_seq with a behavioural mac model.
module tb_dot_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  k_len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0, in_b = 8'd0;
    logic [7:0]  mac_a, mac_b;
    logic        mac_clear;
    logic [15:0] mac_acc = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        in_last = 1'b0;
    logic        len_err;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [7:0]       k;
        int               n;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        int               gap;
        logic [15:0]      exp;
    } vec_t;

    vec_t tv[5];

    dot_seq #(.NBITS(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
`ifdef DOT_SEQ_LAST_CHECK_EN
        , .in_last(in_last), .len_err(len_err)
`endif
    );

`ifndef DOT_SEQ_LAST_CHECK_EN
    assign len_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // mac: clear zeroes the old sum but the current product is still added
    always @(posedge clk)
        mac_acc <= (mac_clear ? 16'd0 : mac_acc) + {8'd0, mac_a} * {8'd0, mac_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] k, input int n,
                                input logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, input logic [15:0] exp);
        vec_t v;
        v.k = k; v.n = n; v.gap = gap; v.exp = exp;
        v.a = {a3, a2, a1, a0};
        v.b = {b3, b2, b1, b0};
        return v;
    endfunction

    // scoreboard: compare each popped FIFO head against the oldest expectation
    always @(negedge clk) begin
        #2;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result unexpected actual=%0d required=none", out_data);
            end else begin
                chk("result", out_data, sb.pop_front());
            end
        end
    end

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b,
                             input logic clr, input logic lst);
        int w;
        in_a = a; in_b = b; in_valid = 1'b1; in_last = lst;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            chk("mac_a", mac_a, a);
            chk("mac_b", mac_b, b);
            chk("mac_clear", mac_clear, clr);
        end
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            #1;
            chk("gap_mac_a", mac_a, 0);
            chk("gap_mac_b", mac_b, 0);
            chk("gap_clear", mac_clear, 0);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tv[0] = mk(8'd3, 3, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 0, 16'd68);
        tv[1] = mk(8'd3, 3, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 2, 16'd68);
        tv[2] = mk(8'd2, 2, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0, 16'd64514);
        tv[3] = mk(8'd0, 1, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 16'd35);
        tv[4] = mk(8'd4, 4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1, 16'd100);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            k_len = tv[i].k;
            out_ready = 1'b1;
            for (int j = 0; j < tv[i].n; j++) begin
                send_pair(tv[i].a[j], tv[i].b[j], j == 0, 1'b0);
                if (j == tv[i].n - 1) begin
                    sb.push_back(tv[i].exp);
                    exp_cnt++;
                    #1;
                    chk("lat_pending", out_valid, 0);
                    @(negedge clk);
                    #1;
                    chk("lat_valid", out_valid, 1);
                    chk("lat_data", out_data, tv[i].exp);
                    chk("lat_count", out_count, exp_cnt);
                end else begin
                    gap(tv[i].gap);
                end
            end
            drain();
        end

        // backpressure with K=1 back-to-back products
        k_len = 8'd1;
        out_ready = 1'b0;
        send_pair(8'd1, 8'd1, 1'b1, 1'b0);
        sb.push_back(16'd1);
        send_pair(8'd2, 8'd2, 1'b1, 1'b0);
        sb.push_back(16'd4);
        #1;
        chk("bp_ready_pending", in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_ready_full", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", out_data, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send_pair(8'd3, 8'd3, 1'b1, 1'b0);
        sb.push_back(16'd9);
        send_pair(8'd4, 8'd4, 1'b1, 1'b0);
        sb.push_back(16'd16);
        exp_cnt += 4;
        drain();
        chk("bp_count", out_count, exp_cnt);

        // reset in the middle of a product
        k_len = 8'd3;
        send_pair(8'd9, 8'd9, 1'b1, 1'b0);
        send_pair(8'd9, 8'd9, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_clear", mac_clear, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", out_count, 0);
        @(negedge clk);
        send_pair(8'd1, 8'd1, 1'b1, 1'b0);
        send_pair(8'd1, 8'd1, 1'b0, 1'b0);
        send_pair(8'd1, 8'd1, 1'b0, 1'b0);
        sb.push_back(16'd3);
        drain();
        repeat (2) @(negedge clk);
        chk("mid_rst_count_after", out_count, 1);

`ifdef DOT_SEQ_LAST_CHECK_EN
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("len_err_rst", len_err, 0);
        @(negedge clk);
        k_len = 8'd2;
        send_pair(8'd3, 8'd4, 1'b1, 1'b1);
        #1;
        chk("len_err_set", len_err, 1);
        @(negedge clk);
        send_pair(8'd5, 8'd6, 1'b0, 1'b1);
        sb.push_back(16'd42);
        drain();
        chk("len_err_sticky", len_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
